// File: rtl/hidden_delta_gen_pkg.sv
// Shared backprop definitions: datapath widths, 16-bit saturation limits and
// the hidden-delta FSM state type.
package hidden_delta_gen_pkg;

    localparam int unsigned PH_W   = 16;
    localparam int unsigned WT_W   = 8;
    localparam int unsigned ACC_W  = 28;
    localparam int unsigned DIF_W  = 16;
    localparam int unsigned PROD_W = PH_W + WT_W;       // ph * w
    localparam int unsigned SCL_W  = PH_W + DIF_W + 1;  // s * {0, h_dif}

    localparam logic signed [PH_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [PH_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StScale,
        StDone
    } state_e;

    // Clamp the wide accumulator into the signed 16-bit delta range.
    function automatic logic signed [PH_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > ACC_W'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (a < ACC_W'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return PH_W'(a);
        end
    endfunction

endpackage

// File: rtl/hidden_delta_gen_mac.sv
// Multiply-shift-accumulate datapath: acc += (ph * w) >>> W_SHIFT per enabled cycle.
module bp_mac
    import hidden_delta_gen_pkg::*;
#(
    parameter int unsigned W_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [PH_W-1:0]  ph,
    input  logic signed [WT_W-1:0]  w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;

    // Full-precision product, then drop weight fraction bits with sign kept.
    always_comb begin
        prod  = PROD_W'(ph) * PROD_W'(w);
        acc_d = acc + ACC_W'(prod >>> W_SHIFT);
    end

    // Accumulator register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/hidden_delta_gen.sv
// Hidden-layer delta generator: accumulates N_OUT weighted output deltas,
// saturates to 16 bits and scales by the hidden activation derivative.
module hidden_delta_gen
    import hidden_delta_gen_pkg::*;
#(
    parameter int unsigned N_OUT   = 4,
    parameter int unsigned W_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIF_W-1:0] h_dif,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PH_W-1:0]  ph_in,
    input  logic [WT_W-1:0]  w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PH_W-1:0]  delta_out,
    output logic             busy
);

    localparam int unsigned CNT_W = 5;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DIF_W-1:0]         h_dif_q, h_dif_d;
    logic [PH_W-1:0]          delta_q, delta_d;
    logic                     in_ready_q, out_valid_q, busy_q;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PH_W-1:0]   sat_s;
    logic signed [SCL_W-1:0]  scaled;

    bp_mac #(
        .W_SHIFT(W_SHIFT)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(mac_clr),
        .en (mac_en),
        .ph (ph_in),
        .w  (w_in),
        .acc(acc)
    );

    // Saturate, then scale by h_dif treated as unsigned Q0.16.
    always_comb begin
        sat_s  = sat16(acc);
        scaled = SCL_W'(sat_s) * SCL_W'($signed({1'b0, h_dif_q}));
    end

    // Next-state logic and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_dif_d = h_dif_q;
        delta_d = delta_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    h_dif_d = h_dif;
                    cnt_d   = '0;
                    mac_clr = 1'b1;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid && in_ready_q) begin
                    mac_en = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_OUT - 1)) begin
                        state_d = StScale;
                    end
                end
            end
            StScale: begin
                delta_d = PH_W'(scaled >>> DIF_W);
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            h_dif_q     <= '0;
            delta_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_dif_q     <= h_dif_d;
            delta_q     <= delta_d;
            in_ready_q  <= (state_d == StAccum);
            out_valid_q <= (state_d == StDone);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign delta_out = delta_q;

endmodule

// File: tb/tb_hidden_delta_gen.sv
// Self-checking bench for hidden_delta_gen against an arithmetic reference model.
module tb_hidden_delta_gen;

    localparam int N  = 4;
    localparam int WS = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] h_dif;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ph_in;
    logic [7:0]  w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] delta_out;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int beat_ph[N];
    int beat_w[N];

    hidden_delta_gen #(
        .N_OUT  (N),
        .W_SHIFT(WS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .h_dif    (h_dif),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ph_in    (ph_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .delta_out(delta_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of (ph*w) floor-shifted, clamp to int16, times h/65536 floored.
    function automatic int model_delta(input int h);
        longint acc = 0;
        longint s;
        for (int i = 0; i < N; i++) begin
            acc += (longint'(beat_ph[i]) * longint'(beat_w[i])) >>> WS;
        end
        s = acc > 32767 ? 32767 : (acc < -32768 ? -32768 : acc);
        return int'((s * longint'(h)) >>> 16);
    endfunction

    function automatic int sdelta();
        return int'($signed(delta_out));
    endfunction

    task automatic set_beats(input int ph, input int w);
        for (int i = 0; i < N; i++) begin
            beat_ph[i] = ph;
            beat_w[i]  = w;
        end
    endtask

    // Drives start plus N beats; gap_mode 0 = back-to-back, 1 = alternate, 2 = random.
    task automatic drive_run(input logic [15:0] h, input int gap_mode,
                             output int got, output bit timed_out);
        int i = 0;
        int cyc = 0;
        int g = 0;
        bit acc_now;
        start = 1'b1;
        h_dif = h;
        tick();
        start = 1'b0;
        while (i < N && cyc < 400) begin
            case (gap_mode)
                1:       in_valid = (cyc % 2 == 0);
                2:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            ph_in = 16'(beat_ph[i]);
            w_in  = 8'(beat_w[i]);
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) i++;
            cyc++;
        end
        in_valid = 1'b0;
        while (!out_valid && g < 6) begin
            tick();
            g++;
        end
        timed_out = !out_valid || (i != N);
        got = sdelta();
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b000 || delta_out !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: in_ready/out_valid/busy=%b delta=%h, required 000/0000",
                     {in_ready, out_valid, busy}, delta_out);
        end
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_ignored_beats();
        int got;
        bit to;
        in_valid = 1'b1;
        ph_in = 16'h7FFF;
        w_in = 8'h7F;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_beats: in_ready=%b busy=%b out_valid=%b required 0/0/0",
                         in_ready, busy, out_valid);
            end
        end
        in_valid = 1'b0;
        set_beats(1024, 64);
        drive_run(16'h8000, 0, got, to);
        tests_run++;
        if (to || got !== 2048) begin
            tests_failed++;
            $display("FAIL pos_vector: delta=%0d timeout=%0b required 2048", got, to);
        end
        handshake();
    endtask

    task automatic test_vectors();
        int got;
        bit to;
        set_beats(-1024, 64);
        drive_run(16'h8000, 0, got, to);
        tests_run++;
        if (to || got !== -2048) begin
            tests_failed++;
            $display("FAIL neg_vector: delta=%0d timeout=%0b required -2048", got, to);
        end
        handshake();
        set_beats(32767, 127);
        drive_run(16'hFFFF, 0, got, to);
        tests_run++;
        if (to || got !== 32766) begin
            tests_failed++;
            $display("FAIL sat_vector: delta=%0d timeout=%0b required 32766", got, to);
        end
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_handshake: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_gaps();
        int got;
        bit to;
        for (int i = 0; i < N; i++) begin
            beat_ph[i] = 100 * (i + 1);
            beat_w[i]  = 64;
        end
        drive_run(16'h4000, 1, got, to);
        tests_run++;
        if (to || got !== 250) begin
            tests_failed++;
            $display("FAIL gap_vector: delta=%0d timeout=%0b required 250", got, to);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int got;
        bit to;
        set_beats(1024, 64);
        drive_run(16'h8000, 0, got, to);
        tests_run++;
        if (to || got !== 2048) begin
            tests_failed++;
            $display("FAIL bp_vector: delta=%0d timeout=%0b required 2048", got, to);
        end
        for (int c = 0; c < 5; c++) begin
            start = 1'(c % 2);
            h_dif = 16'hFFFF;
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || sdelta() !== 2048) begin
                tests_failed++;
                $display("FAIL bp_hold: out_valid=%b delta=%0d required 1/2048",
                         out_valid, sdelta());
            end
        end
        // start in the leaving cycle must not launch a new run
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_exit_start: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || sdelta() !== 2048) begin
            tests_failed++;
            $display("FAIL bp_after: busy=%b delta=%0d required 0/2048", busy, sdelta());
        end
    endtask

    task automatic test_reset_abort();
        int got;
        bit to;
        int pulses = 0;
        start = 1'b1;
        h_dif = 16'h8000;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        ph_in = 16'd1000;
        w_in = 8'd64;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b000 || delta_out !== 16'h0) begin
            tests_failed++;
            $display("FAIL abort_reset: in_ready/out_valid/busy=%b delta=%h required 000/0000",
                     {in_ready, out_valid, busy}, delta_out);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_output: pulses=%0d required 0", pulses);
        end
        set_beats(512, 64);
        drive_run(16'h8000, 0, got, to);
        tests_run++;
        if (to || got !== 1024) begin
            tests_failed++;
            $display("FAIL abort_fresh: delta=%0d timeout=%0b required 1024", got, to);
        end
        // reset while in DONE
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || delta_out !== 16'h0) begin
            tests_failed++;
            $display("FAIL done_reset: out_valid=%b busy=%b delta=%h required 0/0/0000",
                     out_valid, busy, delta_out);
        end
    endtask

    task automatic test_random();
        int got;
        int exp;
        bit to;
        logic [15:0] r16;
        logic [7:0]  r8;
        logic [15:0] h;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                r16 = 16'($urandom);
                r8  = 8'($urandom);
                beat_ph[i] = int'($signed(r16));
                beat_w[i]  = int'($signed(r8));
            end
            h = 16'($urandom);
            exp = model_delta(int'(h));
            drive_run(h, 2, got, to);
            tests_run++;
            if (to || got !== exp) begin
                tests_failed++;
                $display("FAIL random_%0d: delta=%0d timeout=%0b required %0d", t, got, to, exp);
            end
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) tick();
            handshake();
            tests_run++;
            if (busy !== 1'b0 || sdelta() !== exp) begin
                tests_failed++;
                $display("FAIL random_hold_%0d: busy=%b delta=%0d required 0/%0d",
                         t, busy, sdelta(), exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        h_dif = '0;
        in_valid = 1'b0;
        ph_in = '0;
        w_in = '0;
        out_ready = 1'b0;
        test_reset();
        test_ignored_beats();
        test_vectors();
        test_gaps();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
